bsg_mcl_req_arbiter: RTL and testbench

//  Packet-atomic round-robin arbiter that shares one host->manycore request slot between
//  num_req_p host-side 32b word streams (e.g. AXIL MMIO writer, DMA engine). It feeds the
//  32b->packet upsizer of the request slot.
//  - Grants a new packet only when endpoint out-credits and host rcv-fifo vacancy allow it.
//  - Locks the grant for all words of a packet so the words of different packets never mix.

---
 rtl/bsg_manycore_link_to_axil_pkg.sv | 16 +
 rtl/bsg_mcl_rr_picker.sv | 31 +++
 rtl/bsg_mcl_req_arbiter.sv | 140 ++++++++++++++
 tb/tb_bsg_mcl_req_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_manycore_link_to_axil_pkg.sv
// Shared types and sizing for the manycore-link host request path.
// The word count per packet is derived from the link fifo width.
package bsg_manycore_link_to_axil_pkg;

  localparam int mcl_fifo_width_gp    = 128;
  localparam int mcl_word_width_lp    = 32;
  localparam int mcl_words_per_pkt_lp = mcl_fifo_width_gp / mcl_word_width_lp;

  typedef enum logic {eIDLE, eBURST} mcl_arb_state_e;

  // Counter/index width that stays at least 1 bit for degenerate sizes.
  function automatic int mcl_safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bsg_mcl_rr_picker.sv
// Round-robin priority encoder.
// Returns the first eligible index after last_grant_i, wrapping around.
module bsg_mcl_rr_picker
  import bsg_manycore_link_to_axil_pkg::*;
#(
  parameter int num_req_p   = 2,
  parameter int id_width_lp = mcl_safe_clog2(num_req_p)
) (
  input  logic [num_req_p-1:0]   eligible_i,
  input  logic [id_width_lp-1:0] last_grant_i,
  output logic [id_width_lp-1:0] winner_o,
  output logic                   any_v_o
);

  int idx;

  always_comb begin
    winner_o = '0;
    any_v_o  = 1'b0;
    idx      = 0;
    // Offset 1 first so the previous winner is checked last.
    for (int i = 1; i <= num_req_p; i++) begin
      idx = (int'(last_grant_i) + i) % num_req_p;
      if (!any_v_o && eligible_i[idx]) begin
        winner_o = id_width_lp'(idx);
        any_v_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bsg_mcl_req_arbiter.sv
// Packet-atomic round-robin arbiter that shares one host->manycore request slot
// between several 32b word streams; a packet's words are never interleaved.
module bsg_mcl_req_arbiter
  import bsg_manycore_link_to_axil_pkg::*;
#(
  parameter int num_req_p       = 2,
  parameter int words_per_pkt_p = mcl_words_per_pkt_lp,
  parameter int credit_width_p  = 5,
  parameter int min_vacancy_p   = 1,
  localparam int id_width_lp    = mcl_safe_clog2(num_req_p),
  localparam int beat_width_lp  = mcl_safe_clog2(words_per_pkt_p)
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [num_req_p-1:0]             req_v_i,
  input  logic [num_req_p-1:0][31:0]       req_data_i,
  output logic [num_req_p-1:0]             req_ready_o,
  output logic                             fifo_v_o,
  output logic [31:0]                      fifo_data_o,
  input  logic                             fifo_ready_i,
  input  logic [credit_width_p-1:0]        out_credits_i,
  input  logic [31:0]                      rcv_vacancy_i,
  input  logic                             pkt_consumed_i,
  output logic [id_width_lp-1:0]           grant_id_o,
  output logic                             busy_o
);

  // Handshake: a word moves when fifo_v_o & fifo_ready_i, which is exactly
  // req_v_i[sel] & req_ready_o[sel]; valid never depends on ready.

  mcl_arb_state_e             state_q;
  logic [beat_width_lp-1:0]   beat_q;
  logic [id_width_lp-1:0]     grant_q;
  logic [id_width_lp-1:0]     last_grant_q;
  logic [credit_width_p-1:0]  inflight_q, inflight_d;

  logic                       gate_ok;
  logic [num_req_p-1:0]       eligible;
  logic [id_width_lp-1:0]     pick_id;
  logic                       pick_any;
  logic [id_width_lp-1:0]     sel_id;
  logic                       sel_v;
  logic                       in_burst;
  logic                       accept;
  logic                       last_word;
  logic                       pkt_done;

  assign in_burst = (state_q == eBURST);

  // Credits and vacancy only matter when a new packet is about to start.
  assign gate_ok  = (out_credits_i > inflight_q) && (rcv_vacancy_i >= 32'(min_vacancy_p));
  assign eligible = req_v_i & {num_req_p{gate_ok}};

  bsg_mcl_rr_picker #(
    .num_req_p   (num_req_p),
    .id_width_lp (id_width_lp)
  ) picker (
    .eligible_i   (eligible),
    .last_grant_i (last_grant_q),
    .winner_o     (pick_id),
    .any_v_o      (pick_any)
  );

  assign sel_id = in_burst ? grant_q : pick_id;
  assign sel_v  = in_burst ? req_v_i[grant_q] : pick_any;

  assign fifo_v_o    = ~reset_i & sel_v;
  assign fifo_data_o = fifo_v_o ? req_data_i[sel_id] : '0;
  assign busy_o      = ~reset_i & in_burst;
  assign grant_id_o  = reset_i ? '0 : ((in_burst || pick_any) ? sel_id : last_grant_q);

  always_comb begin
    req_ready_o = '0;
    if (fifo_v_o) begin
      req_ready_o[sel_id] = fifo_ready_i;
    end
  end

  assign accept    = fifo_v_o & fifo_ready_i;
  assign last_word = in_burst ? (beat_q == beat_width_lp'(words_per_pkt_p - 1))
                              : (words_per_pkt_p == 1);
  assign pkt_done  = accept & last_word;

  always_comb begin
    inflight_d = inflight_q;
    if (pkt_done && !pkt_consumed_i) begin
      inflight_d = inflight_q + credit_width_p'(1);
    end else if (!pkt_done && pkt_consumed_i) begin
      inflight_d = inflight_q - credit_width_p'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= eIDLE;
      beat_q       <= '0;
      grant_q      <= '0;
      last_grant_q <= id_width_lp'(num_req_p - 1);
      inflight_q   <= '0;
    end else begin
      inflight_q <= inflight_d;
      case (state_q)
        eIDLE: begin
          if (accept) begin
            if (words_per_pkt_p == 1) begin
              last_grant_q <= pick_id;
            end else begin
              state_q <= eBURST;
              grant_q <= pick_id;
              beat_q  <= beat_width_lp'(1);
            end
          end
        end
        eBURST: begin
          if (accept) begin
            if (last_word) begin
              state_q      <= eIDLE;
              beat_q       <= '0;
              last_grant_q <= grant_q;
            end else begin
              beat_q <= beat_q + beat_width_lp'(1);
            end
          end
        end
        default: begin
          state_q <= eIDLE;
          beat_q  <= '0;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  a_inflight_no_underflow: assert property (@(posedge clk_i) disable iff (reset_i)
    !(pkt_consumed_i && (inflight_q == '0)));
  a_inflight_no_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
    !(pkt_done && !pkt_consumed_i && (inflight_q == '1)));
`endif

endmodule

// File: tb/tb_bsg_mcl_req_arbiter.sv
// Directed bench for bsg_mcl_req_arbiter: vector table for single-packet and
// gating cases, hand sequences for contention, backpressure and async reset.
module tb_bsg_mcl_req_arbiter;

  localparam int N  = 2;
  localparam int CW = 5;

  logic              clk = 1'b0;
  logic              reset_i;
  logic [N-1:0]      req_v;
  logic [N-1:0][31:0] req_data;
  logic [N-1:0]      req_ready;
  logic              fifo_v;
  logic [31:0]       fifo_data;
  logic              fifo_ready;
  logic [CW-1:0]     credits;
  logic [31:0]       vacancy;
  logic              consumed;
  logic              grant_id;
  logic              busy;

  always #5 clk = ~clk;

  bsg_mcl_req_arbiter #(
    .num_req_p       (N),
    .words_per_pkt_p (4),
    .credit_width_p  (CW),
    .min_vacancy_p   (1)
  ) dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .req_v_i        (req_v),
    .req_data_i     (req_data),
    .req_ready_o    (req_ready),
    .fifo_v_o       (fifo_v),
    .fifo_data_o    (fifo_data),
    .fifo_ready_i   (fifo_ready),
    .out_credits_i  (credits),
    .rcv_vacancy_i  (vacancy),
    .pkt_consumed_i (consumed),
    .grant_id_o     (grant_id),
    .busy_o         (busy)
  );

  typedef struct {
    logic [1:0]  v;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        rdy;
    logic [4:0]  cred;
    logic [31:0] vac;
    logic        cons;
    logic        e_fv;
    logic [31:0] e_fd;
    logic [1:0]  e_rdy;
    logic        e_gid;
    logic        e_busy;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [1:0] v, input logic [31:0] d0, input logic [31:0] d1,
                              input logic rdy, input logic [4:0] cred, input logic [31:0] vac,
                              input logic cons, input logic e_fv, input logic [31:0] e_fd,
                              input logic [1:0] e_rdy, input logic e_gid, input logic e_busy);
    vec_t r;
    r.v = v; r.d0 = d0; r.d1 = d1; r.rdy = rdy; r.cred = cred; r.vac = vac; r.cons = cons;
    r.e_fv = e_fv; r.e_fd = e_fd; r.e_rdy = e_rdy; r.e_gid = e_gid; r.e_busy = e_busy;
    return r;
  endfunction

  function automatic logic [31:0] cdata(input int r, input int pk, input int w);
    return {(r == 1) ? 8'hB2 : 8'hA2, 8'(pk), 8'h00, 8'(w)};
  endfunction

  task automatic drive(input logic [1:0] v, input logic [31:0] d0, input logic [31:0] d1,
                       input logic rdy, input logic [4:0] cred, input logic [31:0] vac,
                       input logic cons);
    req_v = v; req_data[0] = d0; req_data[1] = d1;
    fifo_ready = rdy; credits = cred; vacancy = vac; consumed = cons;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int wc[2];
    int acc0, bub, got;
    logic in_bub;
    logic [31:0] e;

    // ---- reset: all outputs held low even with live requests
    reset_i = 1'b1;
    drive(2'b11, 32'h1111_1111, 32'h2222_2222, 1'b1, 5'd8, 32'd4, 1'b0);
    #1;
    check("rst_fifo_v", 32'(fifo_v), 32'd0);
    check("rst_fifo_data", fifo_data, 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_gid", 32'(grant_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    next_cycle();
    next_cycle();
    reset_i = 1'b0;
    drive(2'b00, 32'h0, 32'h0, 1'b1, 5'd8, 32'd4, 1'b0);
    #1;
    check("post_rst_gid_last", 32'(grant_id), 32'd1);
    next_cycle();

    // ---- vector table
    // single requester, 4 words, credits 8 vacancy 4
    vecs.push_back(mk(2'b01, 32'hA000_0000, 0, 1, 8, 4, 0, 1, 32'hA000_0000, 2'b01, 0, 0));
    vecs.push_back(mk(2'b01, 32'hA000_0001, 0, 1, 8, 4, 0, 1, 32'hA000_0001, 2'b01, 0, 1));
    vecs.push_back(mk(2'b01, 32'hA000_0002, 0, 1, 8, 4, 0, 1, 32'hA000_0002, 2'b01, 0, 1));
    vecs.push_back(mk(2'b01, 32'hA000_0003, 0, 1, 8, 4, 0, 1, 32'hA000_0003, 2'b01, 0, 1));
    vecs.push_back(mk(2'b00, 0, 0, 1, 8, 4, 0, 0, 0, 2'b00, 0, 0));
    // credit gate: credits 1 with one packet in flight
    vecs.push_back(mk(2'b01, 32'hC000_0000, 0, 1, 1, 4, 0, 0, 0, 2'b00, 0, 0));
    vecs.push_back(mk(2'b01, 32'hC000_0000, 0, 1, 1, 4, 1, 0, 0, 2'b00, 0, 0));
    vecs.push_back(mk(2'b01, 32'hC000_0000, 0, 1, 1, 4, 0, 1, 32'hC000_0000, 2'b01, 0, 0));
    vecs.push_back(mk(2'b01, 32'hC000_0001, 0, 1, 1, 4, 0, 1, 32'hC000_0001, 2'b01, 0, 1));
    vecs.push_back(mk(2'b01, 32'hC000_0002, 0, 1, 1, 4, 0, 1, 32'hC000_0002, 2'b01, 0, 1));
    vecs.push_back(mk(2'b01, 32'hC000_0003, 0, 1, 1, 4, 0, 1, 32'hC000_0003, 2'b01, 0, 1));
    vecs.push_back(mk(2'b00, 0, 0, 1, 8, 4, 1, 0, 0, 2'b00, 0, 0));
    // vacancy gate; vacancy dropping mid-packet must not stall it
    vecs.push_back(mk(2'b10, 0, 32'hD000_0000, 1, 8, 0, 0, 0, 0, 2'b00, 0, 0));
    vecs.push_back(mk(2'b10, 0, 32'hD000_0000, 1, 8, 0, 0, 0, 0, 2'b00, 0, 0));
    vecs.push_back(mk(2'b10, 0, 32'hD000_0000, 1, 8, 1, 0, 1, 32'hD000_0000, 2'b10, 1, 0));
    vecs.push_back(mk(2'b10, 0, 32'hD000_0001, 1, 8, 0, 0, 1, 32'hD000_0001, 2'b10, 1, 1));
    vecs.push_back(mk(2'b10, 0, 32'hD000_0002, 1, 8, 0, 0, 1, 32'hD000_0002, 2'b10, 1, 1));
    vecs.push_back(mk(2'b10, 0, 32'hD000_0003, 1, 8, 0, 0, 1, 32'hD000_0003, 2'b10, 1, 1));
    vecs.push_back(mk(2'b00, 0, 0, 1, 8, 4, 1, 0, 0, 2'b00, 1, 0));
    // upsizer not ready in IDLE: offered but not accepted, grant reverts to last
    vecs.push_back(mk(2'b01, 32'hAB00_0000, 0, 0, 8, 4, 0, 1, 32'hAB00_0000, 2'b00, 0, 0));
    vecs.push_back(mk(2'b00, 0, 0, 1, 8, 4, 0, 0, 0, 2'b00, 1, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].v, vecs[i].d0, vecs[i].d1, vecs[i].rdy, vecs[i].cred, vecs[i].vac, vecs[i].cons);
      #1;
      check($sformatf("vec%0d_fifo_v", i), 32'(fifo_v), 32'(vecs[i].e_fv));
      check($sformatf("vec%0d_fifo_data", i), fifo_v ? fifo_data : 32'h0, vecs[i].e_fd);
      check($sformatf("vec%0d_ready", i), 32'(req_ready), 32'(vecs[i].e_rdy));
      check($sformatf("vec%0d_gid", i), 32'(grant_id), 32'(vecs[i].e_gid));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
      next_cycle();
    end

    // ---- contention: 3 packets each, expected order 0,1,0,1,0,1
    exp_q.delete();
    for (int p = 0; p < 6; p++)
      for (int w = 0; w < 4; w++) exp_q.push_back(cdata(p % 2, p / 2, w));
    wc[0] = 0; wc[1] = 0;
    for (int cyc = 0; cyc < 40 && exp_q.size() > 0; cyc++) begin
      for (int r = 0; r < 2; r++) begin
        req_v[r]    = (wc[r] < 12);
        req_data[r] = cdata(r, wc[r] / 4, wc[r] % 4);
      end
      fifo_ready = 1'b1; credits = 5'd31; vacancy = 32'd4; consumed = 1'b0;
      #1;
      if (fifo_v && fifo_ready) begin
        e = exp_q.pop_front();
        check("contention_data", fifo_data, e);
        check("contention_gid", 32'(grant_id), 32'(e[31:24] == 8'hB2));
      end
      for (int r = 0; r < 2; r++) if (req_v[r] && req_ready[r]) wc[r]++;
      next_cycle();
    end
    check("contention_done", exp_q.size(), 0);
    for (int i = 0; i < 6; i++) begin
      drive(2'b00, 0, 0, 1'b1, 5'd8, 32'd4, 1'b1);
      next_cycle();
    end

    // ---- backpressure + 2-cycle bubble; req1 must stay locked out
    exp_q.delete();
    for (int w = 0; w < 4; w++) exp_q.push_back(32'hE000_0000 | 32'(w));
    acc0 = 0; bub = 0; got = 0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      in_bub      = (acc0 == 2) && (bub < 2);
      req_v[0]    = (acc0 < 4) && !in_bub;
      req_v[1]    = 1'b1;
      req_data[0] = 32'hE000_0000 | 32'(acc0);
      req_data[1] = 32'hF000_0000;
      fifo_ready  = ((cyc % 2) == 0);
      credits = 5'd8; vacancy = 32'd4; consumed = 1'b0;
      #1;
      if (in_bub) begin
        check("bubble_fifo_v", 32'(fifo_v), 32'd0);
        check("bubble_busy", 32'(busy), 32'd1);
        bub++;
      end
      check("bp_gid", 32'(grant_id), 32'd0);
      check("bp_ready1", 32'(req_ready[1]), 32'd0);
      if (fifo_v && fifo_ready) begin
        e = exp_q.pop_front();
        check("bp_data", fifo_data, e);
        got++;
      end
      if (req_v[0] && req_ready[0]) acc0++;
      next_cycle();
    end
    check("bp_done", 32'(got), 32'd4);
    check("bp_bubbles", 32'(bub), 32'd2);

    // ---- async reset at beat 2 of a req1 packet
    drive(2'b11, 32'h6000_0000, 32'h7000_0000, 1'b1, 5'd8, 32'd4, 1'b0);
    #1;
    check("r6_w0_gid", 32'(grant_id), 32'd1);
    check("r6_w0_data", fifo_data, 32'h7000_0000);
    next_cycle();
    req_data[1] = 32'h7000_0001;
    #1;
    check("r6_w1_data", fifo_data, 32'h7000_0001);
    next_cycle();
    req_data[1] = 32'h7000_0002;
    #1;
    check("r6_w2_busy", 32'(busy), 32'd1);
    reset_i = 1'b1;
    #1;
    check("r6_rst_fifo_v", 32'(fifo_v), 32'd0);
    check("r6_rst_ready", 32'(req_ready), 32'd0);
    check("r6_rst_busy", 32'(busy), 32'd0);
    check("r6_rst_gid", 32'(grant_id), 32'd0);
    check("r6_rst_data", fifo_data, 32'd0);
    next_cycle();
    reset_i = 1'b0;
    // credits 1 only passes if inflight was cleared
    drive(2'b11, 32'h6000_0000, 32'h7000_0000, 1'b1, 5'd1, 32'd1, 1'b0);
    #1;
    check("r6_after_fifo_v", 32'(fifo_v), 32'd1);
    check("r6_after_gid", 32'(grant_id), 32'd0);
    check("r6_after_data", fifo_data, 32'h6000_0000);
    check("r6_after_ready", 32'(req_ready), 32'd1);
    check("r6_after_busy", 32'(busy), 32'd0);
    next_cycle();
    drive(2'b00, 0, 0, 1'b1, 5'd8, 32'd4, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
